// File: rtl/key_step.sv
// rtl/key_step.sv - push-button conditioner producing one-cycle step pulses with optional auto-repeat
//
// Purpose: synchronizes a raw, bouncy push-button, debounces press and release,
// and emits a single-cycle step pulse per accepted press, plus periodic repeat
// steps while the key stays held (when REPEAT_EN != 0).
//
// Ports:
//   clk       - system clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   key_raw   - asynchronous raw button level, 1 = pressed
//   step      - registered one-cycle pulse, one LFSR advance per pulse
//   held      - registered debounced key level
//   repeating - registered, high while in auto-repeat

module key_step #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic step,
  output logic held,
  output logic repeating
);

  localparam logic [CNT_W-1:0] deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] dly_last = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] per_last = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] cnt_max  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    st_idle,
    st_press_wait,
    st_held,
    st_repeat,
    st_release_wait
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync1;
  logic             key_s;
  logic             step_nx;
  logic             held_nx;
  logic             rep_nx;

  assign cnt_inc = cnt + CNT_W'(1);

  // held and repeating are pure functions of the next state, registered so
  // they line up with the state they describe.
  assign held_nx = (state_nx == st_held) || (state_nx == st_repeat) ||
                   (state_nx == st_release_wait);
  assign rep_nx  = (state_nx == st_repeat);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      key_s     <= 1'b0;
      state     <= st_idle;
      cnt       <= '0;
      step      <= 1'b0;
      held      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      sync1     <= key_raw;
      key_s     <= sync1;
      state     <= state_nx;
      cnt       <= cnt_nx;
      step      <= step_nx;
      held      <= held_nx;
      repeating <= rep_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    step_nx  = 1'b0;
    case (state)
      st_idle: begin
        if (key_s) begin
          state_nx = st_press_wait;
          cnt_nx   = '0;
        end
      end
      st_press_wait: begin
        if (!key_s) begin
          state_nx = st_idle;
          cnt_nx   = '0;
        end else if (cnt == deb_last) begin
          state_nx = st_held;
          cnt_nx   = '0;
          step_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      st_held: begin
        if (!key_s) begin
          state_nx = st_release_wait;
          cnt_nx   = '0;
        end else if ((REPEAT_EN != 0) && (cnt == dly_last)) begin
          state_nx = st_repeat;
          cnt_nx   = '0;
          step_nx  = 1'b1;
        end else if ((REPEAT_EN != 0) || (cnt != cnt_max)) begin
          // Without repeat the counter has no use here; saturate so a long
          // hold never wraps it.
          cnt_nx = cnt_inc;
        end
      end
      st_repeat: begin
        if (!key_s) begin
          state_nx = st_release_wait;
          cnt_nx   = '0;
        end else if (cnt == per_last) begin
          cnt_nx  = '0;
          step_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      st_release_wait: begin
        if (key_s) begin
          // Release bounce: restart the release debounce, no new step.
          cnt_nx = '0;
        end else if (cnt == deb_last) begin
          state_nx = st_idle;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = st_idle;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_step.sv
// tb/tb_key_step.sv - self-checking bench for key_step with and without auto-repeat

module tb_key_step;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic key_raw;
  logic step0, held0, rep0;
  logic step1, held1, rep1;

  always #5 clk = ~clk;

  key_step #(
    .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .step(step0), .held(held0), .repeating(rep0)
  );

  key_step #(
    .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .step(step1), .held(held1), .repeating(rep1)
  );

  typedef struct {
    int hold;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs [6];

  int   cyc;
  int   n_checks;
  int   n_fail;
  int   nstep0;
  int   nstep1;
  int   q0 [$];
  int   q1 [$];
  logic prev0;
  logic prev1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    if (step0) begin
      if (q0.size() == 0) chk("step0_unexpected", cyc, -1);
      else chk("step0_time", cyc, q0.pop_front());
      chk("step0_consecutive", int'(prev0), 0);
      nstep0++;
    end
    if (q0.size() > 0 && q0[0] < cyc) chk("step0_missed", cyc, q0.pop_front());
    if (step1) begin
      if (q1.size() == 0) chk("step1_unexpected", cyc, -1);
      else chk("step1_time", cyc, q1.pop_front());
      chk("step1_consecutive", int'(prev1), 0);
      nstep1++;
    end
    if (q1.size() > 0 && q1[0] < cyc) chk("step1_missed", cyc, q1.pop_front());
    prev0 = step0;
    prev1 = step1;
  endtask

  // One clock: advance the cycle count on the rising edge, sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // Key driven high at cycle c for h cycles: expected step cycles from the
  // debounce/repeat timing rules (first edge sampling the key is c+1).
  task automatic push_press(input int c, input int h);
    int f;
    if (h >= D + 1) begin
      f = c + D + 3;
      q0.push_back(f);
      q1.push_back(f);
      for (int s = f + RD; s < c + h + 3; s += RP) q1.push_back(s);
    end
  endtask

  task automatic press(input int h, input int gap);
    int c;
    c = cyc;
    key_raw = 1'b1;
    push_press(c, h);
    repeat (h) tick();
    key_raw = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int c;
    int m;
    int b0;
    int b1;
    vecs[0] = '{hold: 3,  exp0: 0, exp1: 0};
    vecs[1] = '{hold: 4,  exp0: 0, exp1: 0};
    vecs[2] = '{hold: 5,  exp0: 1, exp1: 1};
    vecs[3] = '{hold: 14, exp0: 1, exp1: 1};
    vecs[4] = '{hold: 15, exp0: 1, exp1: 2};
    vecs[5] = '{hold: 30, exp0: 1, exp1: 7};

    cyc = 0; n_checks = 0; n_fail = 0; nstep0 = 0; nstep1 = 0;
    prev0 = 1'b0; prev1 = 1'b0;
    rst = 1'b1;
    key_raw = 1'b0;
    tick();
    tick();
    chk("rst_step0", int'(step0), 0);
    chk("rst_held0", int'(held0), 0);
    chk("rst_rep0", int'(rep0), 0);
    chk("rst_step1", int'(step1), 0);
    chk("rst_held1", int'(held1), 0);
    chk("rst_rep1", int'(rep1), 0);
    rst = 1'b0;
    repeat (5) tick();

    // Table: press lengths around the debounce and repeat thresholds.
    for (int i = 0; i < 6; i++) begin
      b0 = nstep0;
      b1 = nstep1;
      press(vecs[i].hold, 20);
      chk($sformatf("vec%0d_steps0", i), nstep0 - b0, vecs[i].exp0);
      chk($sformatf("vec%0d_steps1", i), nstep1 - b1, vecs[i].exp1);
      chk($sformatf("vec%0d_held0", i), int'(held0), 0);
      chk($sformatf("vec%0d_held1", i), int'(held1), 0);
    end

    // Clean press, 30 cycles: held timing on the non-repeating instance.
    c = cyc;
    key_raw = 1'b1;
    push_press(c, 30);
    wait_to(c + D + 2);
    chk("t1_held_before", int'(held0), 0);
    tick();
    chk("t1_held_at_step", int'(held0), 1);
    chk("t1_rep0", int'(rep0), 0);
    wait_to(c + 30);
    key_raw = 1'b0;
    m = cyc;
    wait_to(m + D + 2);
    chk("t1_held_release_wait", int'(held0), 1);
    chk("t1_rep0_late", int'(rep0), 0);
    tick();
    chk("t1_held_fall", int'(held0), 0);
    repeat (10) tick();

    // Press bounce 1,0,1,0 then stable high.
    key_raw = 1'b1; tick();
    key_raw = 1'b0; tick();
    key_raw = 1'b1; tick();
    key_raw = 1'b0; tick();
    c = cyc;
    key_raw = 1'b1;
    push_press(c, 8);
    wait_to(c + D + 2);
    chk("t2_held_before", int'(held0), 0);
    tick();
    chk("t2_held_at_step", int'(held0), 1);
    wait_to(c + 8);
    key_raw = 1'b0;
    repeat (20) tick();

    // Auto-repeat: release seen 25 cycles after the first step.
    c = cyc;
    key_raw = 1'b1;
    push_press(c, 29);
    wait_to(c + D + 3 + RD - 1);
    chk("t3_rep_before", int'(rep1), 0);
    tick();
    chk("t3_rep_start", int'(rep1), 1);
    wait_to(c + 29);
    key_raw = 1'b0;
    wait_to(c + D + 3 + 24);
    chk("t3_rep_hold", int'(rep1), 1);
    tick();
    chk("t3_rep_end", int'(rep1), 0);
    chk("t3_held_release", int'(held1), 1);
    repeat (20) tick();

    // Release bounce: low 2, high 1, then stable low.
    c = cyc;
    key_raw = 1'b1;
    push_press(c, 9);
    wait_to(c + 9);
    m = cyc;
    key_raw = 1'b0; tick();
    tick();
    key_raw = 1'b1; tick();
    key_raw = 1'b0;
    wait_to(m + 8);
    chk("t4_held0_before", int'(held0), 1);
    chk("t4_held1_before", int'(held1), 1);
    tick();
    chk("t4_held0_fall", int'(held0), 0);
    chk("t4_held1_fall", int'(held1), 0);
    repeat (20) tick();

    // Reset in the third cycle of press debounce, key kept high.
    c = cyc;
    key_raw = 1'b1;
    wait_to(c + 5);
    rst = 1'b1;
    tick();
    chk("t5_step0", int'(step0), 0);
    chk("t5_held0", int'(held0), 0);
    chk("t5_rep0", int'(rep0), 0);
    chk("t5_step1", int'(step1), 0);
    chk("t5_held1", int'(held1), 0);
    chk("t5_rep1", int'(rep1), 0);
    rst = 1'b0;
    push_press(cyc, 8);
    wait_to(c + 6 + D + 2);
    chk("t5_held_before", int'(held0), 0);
    tick();
    chk("t5_held_at_step", int'(held0), 1);
    wait_to(c + 14);
    key_raw = 1'b0;
    repeat (20) tick();

    // Short press: 3 cycles high, nothing may appear.
    key_raw = 1'b1;
    repeat (3) tick();
    key_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_held0", int'(held0), 0);
      chk("t6_held1", int'(held1), 0);
      chk("t6_rep1", int'(rep1), 0);
    end

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
